rtc_bus_arbiter: RTL and testbench
==================================

// Module: rtc_bus_arbiter
// PURPOSE
//  Shares the single RTC bus-cycle engine among three requesters: init sequencer, user write, periodic read.
//  Fixed priority: init > write > read. Non-preemptive, one transaction per grant.
//  Sits between the requesters and the bus-cycle engine (start/done handshake).
//  Also returns read data and flags bus timeouts.
// PARAMETERS
//  TIMEOUT  12'h0ff  max cycles in WAIT before a transaction is aborted
// PORTS
//  clk        in   1  system clock
//  reset      in   1  synchronous, active-high reset
//  init_req   in   1  init requester: transaction pending, held until init_ack
//  init_addr  in   8  init RTC register address
//  init_data  in   8  init write data (init is always a write)
//  wr_req     in   1  user-write requester: pending, held until wr_ack
//  wr_addr    in   8  user-write address
//  wr_data    in   8  user-write data
//  rd_req     in   1  read requester: pending, held until rd_ack
//  rd_addr    in   8  read address
//  init_ack   out  1  one-cycle pulse: init transaction finished
//  wr_ack     out  1  one-cycle pulse: write transaction finished
//  rd_ack     out  1  one-cycle pulse: read transaction finished
//  rd_data    out  8  last successfully read byte, held until next read
//  rd_valid   out  1  one-cycle pulse with rd_ack on successful read
//  grant      out  2  current owner: 00 none, 01 init, 10 write, 11 read
//  bus_start  out  1  one-cycle pulse launching a bus cycle
//  bus_we     out  1  1 = write cycle, 0 = read cycle; stable from ISSUE to end of WAIT
//  bus_addr   out  8  latched transaction address
//  bus_wdata  out  8  latched write data (00 for reads)
//  bus_done   in   1  engine pulse: bus cycle complete
//  bus_rdata  in   8  engine read data, valid with bus_done
//  timeout_err out 1  sticky: a transaction timed out; cleared only by reset
// BEHAVIOUR
//  Reset (sync, any state): state=IDLE; all outputs 0; wait counter=0.
//  FSM: IDLE -> ISSUE -> WAIT -> RELEASE -> IDLE.
//  - IDLE
//    - Sample requests; choose the highest-priority one.
//    - Latch addr/data/we into bus_* registers and set grant.
//    - Go to ISSUE. No request: stay, grant=00.
//  - ISSUE: bus_start=1 for exactly this cycle; clear wait counter; go to WAIT.
//  - WAIT
//    - Counter +1 per cycle.
//    - bus_done: go to RELEASE. On a read, capture bus_rdata into rd_data.
//    - Counter==TIMEOUT with no done: set timeout_err; go to RELEASE; rd_data unchanged.
//    - bus_done on the same cycle as TIMEOUT: treated as done, no error.
//  - RELEASE
//    - Owner's ack=1 for this cycle only; rd_valid=1 only for a successful read.
//    - grant->00 next cycle; go to IDLE.
//    - Requester drops req on the edge after ack. IDLE therefore never re-samples a stale req.
//  Latency
//    - req high in IDLE at cycle n -> bus_start at n+1.
//    - Ack at bus_done cycle+1. Min 4 cycles per transaction.
//  Request handling
//    - Requests are sampled only in IDLE. Req edges during ISSUE/WAIT/RELEASE are ignored.
//    - A dropped req does not abort an in-flight cycle.
//  Simultaneous requests: priority decides. The loser waits; no fairness, so init can starve others by design.
//  bus_done outside WAIT is ignored.
//  Reset mid-transaction: abort immediately, no ack, outputs 0. The engine is reset by the same reset.
// STRUCTURE
//  Shared header rtc_defs.vh:
//  - state codes ST_IDLE/ST_ISSUE/ST_WAIT/ST_RELEASE
//  - grant codes G_NONE/G_INIT/G_WR/G_RD
//  - TIMEOUT default value
//  Sub-module rtc_arb_prio: combinational 3-input fixed-priority encoder -> grant code.
//  Everything else (FSM, latches, wait counter) lives in this module.
// TESTING
//  1. Init only: init_req, addr 02, data 10; done 5 cycles after start.
//     -> bus_we=1, addr 02, wdata 10; init_ack one cycle after done; grant 01 then 00.
//  2. All three reqs together.
//     -> Order init, write, read; exactly one bus_start per grant; no overlap; each ack once.
//  3. Read: rd_req, addr 21; bus_rdata 59 with done.
//     -> rd_data=59, rd_valid and rd_ack same cycle; bus_wdata=00.
//  4. No bus_done.
//     -> After TIMEOUT (0ff) WAIT cycles: timeout_err=1, owner ack, rd_valid=0.
//     -> Next request still served; timeout_err stays 1 until reset.
//  5. Reset asserted during WAIT.
//     -> Next cycle all outputs 0, IDLE, no ack; new req served normally.
//  6. Requester holds req 1 cycle past ack: no duplicate transaction.
//     Stray bus_done in IDLE: no effect.

Source files
------------

// File: rtl/rtc_bus_arbiter_pkg.sv
// rtl/rtc_bus_arbiter_pkg.sv - shared codes and defaults for the RTC bus arbiter
//
// Purpose: FSM state codes, grant (owner) codes and the default WAIT
//          timeout shared by rtc_bus_arbiter and rtc_arb_prio.
// Ports:   none (package).

package rtc_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  localparam logic [1:0] G_NONE = 2'b00;
  localparam logic [1:0] G_INIT = 2'b01;
  localparam logic [1:0] G_WR   = 2'b10;
  localparam logic [1:0] G_RD   = 2'b11;

  localparam logic [11:0] TIMEOUT_DEFAULT = 12'h0ff;

endpackage

// File: rtl/rtc_arb_prio.sv
// rtl/rtc_arb_prio.sv - fixed-priority encoder for the three RTC requesters
//
// Purpose: maps the pending requests to the owner code of the highest
//          priority requester (init > write > read), G_NONE when idle.
// Ports:
//   init_req   in  1  init sequencer request
//   wr_req     in  1  user-write request
//   rd_req     in  1  periodic-read request
//   grant_code out 2  G_NONE / G_INIT / G_WR / G_RD

module rtc_arb_prio
  import rtc_bus_arbiter_pkg::*;
(
  input  logic       init_req,
  input  logic       wr_req,
  input  logic       rd_req,
  output logic [1:0] grant_code
);

  always_comb begin
    grant_code = G_NONE;
    if (init_req) begin
      grant_code = G_INIT;
    end else if (wr_req) begin
      grant_code = G_WR;
    end else if (rd_req) begin
      grant_code = G_RD;
    end
  end

endmodule

// File: rtl/rtc_bus_arbiter.sv
// rtl/rtc_bus_arbiter.sv - shares the RTC bus-cycle engine among three requesters
//
// Purpose: non-preemptive fixed-priority arbiter (init > write > read) in
//          front of the bus-cycle engine. One transaction per grant, read
//          data return and a sticky bus-timeout flag.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   init_req/init_addr/init_data    init requester (always a write)
//   wr_req/wr_addr/wr_data          user-write requester
//   rd_req/rd_addr                  read requester
//   init_ack/wr_ack/rd_ack   out    one-cycle completion pulses
//   rd_data/rd_valid         out    last good read byte / success pulse
//   grant                    out    current owner code
//   bus_start/bus_we/bus_addr/bus_wdata  out  engine command
//   bus_done/bus_rdata       in     engine completion and read data
//   timeout_err              out    sticky timeout flag

module rtc_bus_arbiter
  import rtc_bus_arbiter_pkg::*;
#(
  parameter logic [11:0] TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       init_req,
  input  logic [7:0] init_addr,
  input  logic [7:0] init_data,
  input  logic       wr_req,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       rd_req,
  input  logic [7:0] rd_addr,
  output logic       init_ack,
  output logic       wr_ack,
  output logic       rd_ack,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic [1:0] grant,
  output logic       bus_start,
  output logic       bus_we,
  output logic [7:0] bus_addr,
  output logic [7:0] bus_wdata,
  input  logic       bus_done,
  input  logic [7:0] bus_rdata,
  output logic       timeout_err
);

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        bus_we_q, bus_we_d;
  logic [7:0]  bus_addr_q, bus_addr_d;
  logic [7:0]  bus_wdata_q, bus_wdata_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic [11:0] cnt_q, cnt_d;
  logic        timeout_err_q, timeout_err_d;
  // Marks that the transaction now in RELEASE was aborted, so rd_valid stays low.
  logic        aborted_q, aborted_d;

  logic [1:0]  prio_grant;

  rtc_arb_prio u_prio (
    .init_req   (init_req),
    .wr_req     (wr_req),
    .rd_req     (rd_req),
    .grant_code (prio_grant)
  );

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    bus_we_d      = bus_we_q;
    bus_addr_d    = bus_addr_q;
    bus_wdata_d   = bus_wdata_q;
    rd_data_d     = rd_data_q;
    cnt_d         = cnt_q;
    timeout_err_d = timeout_err_q;
    aborted_d     = aborted_q;

    unique case (state_q)
      ST_IDLE: begin
        if (prio_grant != G_NONE) begin
          grant_d = prio_grant;
          state_d = ST_ISSUE;
          unique case (prio_grant)
            G_INIT: begin
              bus_we_d    = 1'b1;
              bus_addr_d  = init_addr;
              bus_wdata_d = init_data;
            end
            G_WR: begin
              bus_we_d    = 1'b1;
              bus_addr_d  = wr_addr;
              bus_wdata_d = wr_data;
            end
            default: begin
              bus_we_d    = 1'b0;
              bus_addr_d  = rd_addr;
              bus_wdata_d = 8'h00;
            end
          endcase
        end
      end
      ST_ISSUE: begin
        cnt_d     = 12'd0;
        aborted_d = 1'b0;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 12'd1;
        // A done arriving on the very cycle the count reaches TIMEOUT still wins.
        if (bus_done) begin
          state_d = ST_RELEASE;
          if (grant_q == G_RD) begin
            rd_data_d = bus_rdata;
          end
        end else if (cnt_d == TIMEOUT) begin
          timeout_err_d = 1'b1;
          aborted_d     = 1'b1;
          state_d       = ST_RELEASE;
        end
      end
      default: begin
        grant_d = G_NONE;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      grant_q       <= G_NONE;
      bus_we_q      <= 1'b0;
      bus_addr_q    <= 8'h00;
      bus_wdata_q   <= 8'h00;
      rd_data_q     <= 8'h00;
      cnt_q         <= 12'd0;
      timeout_err_q <= 1'b0;
      aborted_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      bus_we_q      <= bus_we_d;
      bus_addr_q    <= bus_addr_d;
      bus_wdata_q   <= bus_wdata_d;
      rd_data_q     <= rd_data_d;
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
      aborted_q     <= aborted_d;
    end
  end

  assign bus_start   = (state_q == ST_ISSUE);
  assign init_ack    = (state_q == ST_RELEASE) && (grant_q == G_INIT);
  assign wr_ack      = (state_q == ST_RELEASE) && (grant_q == G_WR);
  assign rd_ack      = (state_q == ST_RELEASE) && (grant_q == G_RD);
  assign rd_valid    = rd_ack && !aborted_q;
  assign grant       = grant_q;
  assign bus_we      = bus_we_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wdata   = bus_wdata_q;
  assign rd_data     = rd_data_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// tb/tb_rtc_bus_arbiter.sv - self-checking bench for rtc_bus_arbiter

module tb_rtc_bus_arbiter;

  localparam int TO = 255;

  logic       clk = 1'b0;
  logic       reset;
  logic       init_req, wr_req, rd_req;
  logic [7:0] init_addr, init_data, wr_addr, wr_data, rd_addr;
  logic       init_ack, wr_ack, rd_ack, rd_valid, bus_start, bus_we, timeout_err;
  logic [7:0] rd_data, bus_addr, bus_wdata, bus_rdata;
  logic [1:0] grant;
  logic       bus_done;

  rtc_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .init_req(init_req), .init_addr(init_addr), .init_data(init_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_addr(rd_addr),
    .init_ack(init_ack), .wr_ack(wr_ack), .rd_ack(rd_ack),
    .rd_data(rd_data), .rd_valid(rd_valid), .grant(grant),
    .bus_start(bus_start), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_done(bus_done), .bus_rdata(bus_rdata), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] req;              // bit0 init, bit1 write, bit2 read
    logic [7:0] ia, id, wa, wd, ra;
    int         delay;            // done this many cycles after start, 0 = never
    logic [7:0] rdata;
    logic [1:0] eg;
    logic [7:0] ea, ew;
    logic       rv;
    logic [7:0] erd;
    logic       et;
  } rec_t;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [2:0] req_v;
  logic [7:0] addr_v [3];
  logic [7:0] data_v [3];

  // transaction-level reference model state
  bit         free_m, start_exp, in_txn, to_m, exp_we, terr_model;
  int         owner, s_cyc, ack_cyc, done_cyc;
  int         drop_at [3];
  logic [7:0] exp_addr, exp_wdata, rdat_m, rd_model;
  int         start_log [$];

  rec_t tbl [9];

  function automatic rec_t mk(logic [2:0] req, logic [7:0] ia, logic [7:0] id, logic [7:0] wa,
                              logic [7:0] wd, logic [7:0] ra, int delay, logic [7:0] rdata,
                              logic [1:0] eg, logic [7:0] ea, logic [7:0] ew, logic rv,
                              logic [7:0] erd, logic et);
    rec_t r;
    r.req = req; r.ia = ia; r.id = id; r.wa = wa; r.wd = wd; r.ra = ra;
    r.delay = delay; r.rdata = rdata; r.eg = eg; r.ea = ea; r.ew = ew;
    r.rv = rv; r.erd = erd; r.et = et;
    return r;
  endfunction

  function automatic logic [2:0] onehot(int o);
    case (o)
      1: return 3'b001;
      2: return 3'b010;
      3: return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // highest-priority pending requester: 1 init, 2 write, 3 read
  function automatic int pick(logic [2:0] r);
    if (r[0]) return 1;
    if (r[1]) return 2;
    if (r[2]) return 3;
    return 0;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push();
    init_req = req_v[0]; init_addr = addr_v[0]; init_data = data_v[0];
    wr_req   = req_v[1]; wr_addr   = addr_v[1]; wr_data   = data_v[1];
    rd_req   = req_v[2]; rd_addr   = addr_v[2];
  endtask

  task automatic do_txn(input rec_t r);
    int k_ack;
    req_v = r.req;
    addr_v[0] = r.ia; data_v[0] = r.id;
    addr_v[1] = r.wa; data_v[1] = r.wd;
    addr_v[2] = r.ra; data_v[2] = 8'h00;
    push();
    tick();
    chk("start", {31'd0, bus_start}, 1);
    chk("grant", {30'd0, grant}, {30'd0, r.eg});
    chk("bus_we", {31'd0, bus_we}, {31'd0, (r.eg != 2'd3)});
    chk("bus_addr", {24'd0, bus_addr}, {24'd0, r.ea});
    chk("bus_wdata", {24'd0, bus_wdata}, {24'd0, r.ew});
    k_ack = -1;
    for (int k = 1; k <= TO + 3; k++) begin
      tick();
      bus_done = 1'b0;
      if (init_ack || wr_ack || rd_ack) begin
        k_ack = k;
        break;
      end
      chk("we_stable", {31'd0, bus_we}, {31'd0, (r.eg != 2'd3)});
      if (k == r.delay) begin
        bus_done  = 1'b1;
        bus_rdata = r.rdata;
      end
    end
    chk("ack_cycle", k_ack, (r.delay != 0) ? r.delay + 1 : TO + 1);
    chk("ack_vec", {29'd0, rd_ack, wr_ack, init_ack}, {29'd0, onehot(int'(r.eg))});
    chk("rd_valid", {31'd0, rd_valid}, {31'd0, r.rv});
    chk("rd_data", {24'd0, rd_data}, {24'd0, r.erd});
    chk("timeout_err", {31'd0, timeout_err}, {31'd0, r.et});
    tick();
    chk("grant_release", {30'd0, grant}, 0);
    chk("ack_once", {29'd0, rd_ack, wr_ack, init_ack}, 0);
    req_v = 3'b000;
    push();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("no_dup_start", {31'd0, bus_start}, 0);
    end
  endtask

  task automatic run_model(input int ncyc, input bit allow_new, input bit allow_to);
    bit is_ack, in_wait;
    for (int n = 0; n < ncyc; n++) begin
      tick();
      chk("m_start", {31'd0, bus_start}, {31'd0, start_exp});
      if (start_exp) begin
        in_txn = 1'b1;
        s_cyc  = cyc;
        start_log.push_back(owner);
        chk("m_bus_we", {31'd0, bus_we}, {31'd0, exp_we});
        chk("m_bus_addr", {24'd0, bus_addr}, {24'd0, exp_addr});
        chk("m_bus_wdata", {24'd0, bus_wdata}, {24'd0, exp_wdata});
        if (allow_to && $urandom_range(0, 19) == 0) begin
          to_m = 1'b1; done_cyc = -1; ack_cyc = cyc + TO + 1;
        end else begin
          to_m = 1'b0; done_cyc = cyc + int'($urandom_range(1, 6)); ack_cyc = done_cyc + 1;
          rdat_m = 8'($urandom);
        end
      end
      chk("m_grant", {30'd0, grant}, in_txn ? owner : 0);
      is_ack  = in_txn && (cyc == ack_cyc);
      in_wait = in_txn && (cyc > s_cyc) && (cyc < ack_cyc);
      chk("m_acks", {29'd0, rd_ack, wr_ack, init_ack}, is_ack ? {29'd0, onehot(owner)} : 0);
      chk("m_rd_valid", {31'd0, rd_valid}, {31'd0, (is_ack && owner == 3 && !to_m)});
      if (is_ack && owner == 3 && !to_m) rd_model = rdat_m;
      if (is_ack && to_m) terr_model = 1'b1;
      chk("m_rd_data", {24'd0, rd_data}, {24'd0, rd_model});
      chk("m_timeout_err", {31'd0, timeout_err}, {31'd0, terr_model});
      if (is_ack) begin
        in_txn = 1'b0;
        drop_at[owner-1] = cyc + 1;
      end
      for (int i = 0; i < 3; i++) begin
        if (drop_at[i] == cyc) begin
          req_v[i] = 1'b0;
        end else if (allow_new && !req_v[i] && cyc > drop_at[i] && $urandom_range(0, 7) == 0) begin
          req_v[i]  = 1'b1;
          addr_v[i] = 8'($urandom);
          data_v[i] = 8'($urandom);
        end
      end
      if (cyc == done_cyc) begin
        bus_done = 1'b1; bus_rdata = rdat_m;
      end else if (!in_wait && $urandom_range(0, 5) == 0) begin
        bus_done = 1'b1; bus_rdata = 8'($urandom);
      end else begin
        bus_done = 1'b0;
      end
      push();
      start_exp = free_m && (req_v != 3'b000);
      if (start_exp) begin
        owner     = pick(req_v);
        exp_we    = (owner != 3);
        exp_addr  = addr_v[owner-1];
        exp_wdata = (owner == 3) ? 8'h00 : data_v[owner-1];
        free_m    = 1'b0;
      end
      if (is_ack) free_m = 1'b1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = mk(3'b001, 8'h02, 8'h10, 8'h00, 8'h00, 8'h00,   5, 8'h00, 2'd1, 8'h02, 8'h10, 1'b0, 8'h00, 1'b0);
    tbl[1] = mk(3'b100, 8'h00, 8'h00, 8'h00, 8'h00, 8'h21,   1, 8'h59, 2'd3, 8'h21, 8'h00, 1'b1, 8'h59, 1'b0);
    tbl[2] = mk(3'b010, 8'h00, 8'h00, 8'h33, 8'h44, 8'h00,   3, 8'haa, 2'd2, 8'h33, 8'h44, 1'b0, 8'h59, 1'b0);
    tbl[3] = mk(3'b110, 8'h00, 8'h00, 8'h5a, 8'hc3, 8'h7e,   2, 8'h11, 2'd2, 8'h5a, 8'hc3, 1'b0, 8'h59, 1'b0);
    tbl[4] = mk(3'b111, 8'h01, 8'hff, 8'h5a, 8'hc3, 8'h7e,   4, 8'h22, 2'd1, 8'h01, 8'hff, 1'b0, 8'h59, 1'b0);
    tbl[5] = mk(3'b101, 8'h0c, 8'h0d, 8'h00, 8'h00, 8'h7e,   1, 8'h33, 2'd1, 8'h0c, 8'h0d, 1'b0, 8'h59, 1'b0);
    tbl[6] = mk(3'b100, 8'h00, 8'h00, 8'h00, 8'h00, 8'h3c,  TO, 8'h9d, 2'd3, 8'h3c, 8'h00, 1'b1, 8'h9d, 1'b0);
    tbl[7] = mk(3'b100, 8'h00, 8'h00, 8'h00, 8'h00, 8'h40,   0, 8'hee, 2'd3, 8'h40, 8'h00, 1'b0, 8'h9d, 1'b1);
    tbl[8] = mk(3'b010, 8'h00, 8'h00, 8'h66, 8'h77, 8'h00,   2, 8'h00, 2'd2, 8'h66, 8'h77, 1'b0, 8'h9d, 1'b1);

    reset = 1'b1;
    req_v = 3'b000;
    for (int i = 0; i < 3; i++) begin
      addr_v[i] = 8'h00; data_v[i] = 8'h00;
    end
    push();
    bus_done = 1'b0; bus_rdata = 8'h00;
    repeat (3) tick();
    chk("rst_grant", {30'd0, grant}, 0);
    chk("rst_outs", {24'd0, bus_start, bus_we, init_ack, wr_ack, rd_ack, rd_valid, timeout_err, 1'b0}, 0);
    chk("rst_bus_addr", {24'd0, bus_addr}, 0);
    chk("rst_rd_data", {24'd0, rd_data}, 0);
    reset = 1'b0;
    tick();

    foreach (tbl[i]) do_txn(tbl[i]);

    // reset in the middle of WAIT
    req_v = 3'b100; addr_v[2] = 8'h21;
    push();
    tick();
    chk("rw_start", {31'd0, bus_start}, 1);
    tick();
    tick();
    reset = 1'b1; req_v = 3'b000;
    push();
    tick();
    reset = 1'b0;
    chk("rw_grant", {30'd0, grant}, 0);
    chk("rw_outs", {24'd0, bus_start, bus_we, init_ack, wr_ack, rd_ack, rd_valid, timeout_err, 1'b0}, 0);
    chk("rw_addr_wdata", {16'd0, bus_addr, bus_wdata}, 0);
    chk("rw_rd_data", {24'd0, rd_data}, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rw_no_ack", {29'd0, rd_ack, wr_ack, init_ack}, 0);
    end
    do_txn(mk(3'b010, 8'h00, 8'h00, 8'h12, 8'h34, 8'h00, 2, 8'h00, 2'd2, 8'h12, 8'h34, 1'b0, 8'h00, 1'b0));

    // all three requests together, then randomized traffic with stray dones
    free_m = 1'b1; start_exp = 1'b0; in_txn = 1'b0; to_m = 1'b0;
    owner = 0; s_cyc = 0; ack_cyc = -1; done_cyc = -1;
    rd_model = 8'h00; terr_model = 1'b0; rdat_m = 8'h00;
    for (int i = 0; i < 3; i++) drop_at[i] = -10;
    req_v = 3'b111;
    addr_v[0] = 8'h0a; data_v[0] = 8'ha0;
    addr_v[1] = 8'h0b; data_v[1] = 8'hb0;
    addr_v[2] = 8'h0c; data_v[2] = 8'h00;
    run_model(50, 1'b0, 1'b0);
    chk("all3_count", start_log.size(), 3);
    for (int i = 0; i < 3 && i < start_log.size(); i++) chk("all3_order", start_log[i], i + 1);

    run_model(3000, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
